sort_frame_loader: RTL
======================

Name: sort_frame_loader

Overview:
- Upstream input stage of the 4-input 16-bit descending sorter.
- Accepts a serial stream of words over a valid/ready handshake and packs them four at a time into a frame. Word 0 → a, word 1 → b, word 2 → c, word 3 → d.
- Presents each frame on stable parallel outputs a/b/c/d to the sorter's greatest-output stage, with a frame-level valid/ready handshake.
- Double-buffered: a fill buffer and a hold buffer, so the next frame loads while the current one waits to be consumed.

Parameters:
- WIDTH, 16, word width of in_data and of a/b/c/d.
- PAD, 16'h0000, value written into lanes left unfilled by an early in_last.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  incoming word.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the current word as the last of a short frame; sampled only on a handshake.
- in_ready  output  1  loader can accept a word.
- a, b, c, d  output  WIDTH each  frame lanes 0..3.
- lane_mask  output  4  bit k set = lane k holds real data, clear = PAD.
- frame_valid  output  1  a/b/c/d/lane_mask hold a complete frame.
- frame_ready  input  1  downstream consumes the frame.
- frame_count  output  8  frames delivered; wraps 255→0.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - a, b, c, d = 0; lane_mask = 0; frame_valid = 0; frame_count = 0.
  - Fill index = 0; fill_full = 0; therefore in_ready = 1.
- Reset asserted mid-operation discards any partial fill and any held frame immediately. No frame is emitted for discarded data.
- Input handshake: accept = in_valid & in_ready. in_ready = ~fill_full, decoded from state only, with no combinational path from in_valid or frame_ready.
- Fill FSM states: FILLING(idx 0..3) and FULL.
  - On accept in FILLING(k): lane k ← in_data and mask bit k ← 1.
  - If k==3 or in_last=1, go to FULL. Every lane j>k that is unwritten is set to PAD with mask bit 0. Otherwise go to FILLING(k+1).
  - in_last on the 4th word is legal and identical to no in_last.
- Transfer: on any edge where fill is FULL and (frame_valid==0 or frame_ready==1):
  - hold ← fill (lanes and mask); frame_valid ← 1.
  - Fill returns to FILLING(0) with mask cleared.
- Consume: on an edge with frame_valid & frame_ready and no transfer, frame_valid ← 0. Lanes and mask keep their last values and are don't-care.
- frame_count increments by 1 on every edge with frame_valid & frame_ready, including the simultaneous consume+transfer case. It wraps modulo 256.
- Stability: while frame_valid=1 and frame_ready=0, a/b/c/d and lane_mask must not change.
- Latency:
  - Last word accepted on edge E; with the hold buffer empty, transfer happens on edge E+1, so frame_valid is high after E+1.
  - Steady state is 5 cycles per frame (4 accepts + 1 transfer cycle) when frame_ready is held high.
- Backpressure: if the hold buffer is occupied and frame_ready=0, fill stays FULL and in_ready stays 0. No word is ever dropped or overwritten.
- Simultaneous consume + transfer in one edge: frame_valid stays 1, the new frame replaces the old one, and frame_count increments.
- in_valid while in_ready=0: no effect, and in_data is not sampled.
- frame_ready while frame_valid=0: no effect.

Test Plan:
- Reset then 4 accepts: 16'h0003, 16'h8000, 16'h0001, 16'hFFFF with frame_ready=1.
  - Required: a=0003, b=8000, c=0001, d=FFFF; lane_mask=4'b1111.
  - frame_valid high exactly 1 cycle after E+1; frame_count=1.
- Short frame: 16'h1234 then 16'h00AA with in_last=1.
  - Required: a=1234, b=00AA, c=d=0000; lane_mask=4'b0011.
- Backpressure: frame_ready=0, stream 8 words 1..8.
  - Required: frame1 (1,2,3,4) held stable; after 4 more accepts, in_ready=0 and words 5..8 stay in the fill buffer.
  - Raise frame_ready for one cycle: frame2 (5,6,7,8) appears next cycle, frame_valid stays 1, frame_count=1, in_ready returns to 1.
- Continuous stream, frame_ready=1, 260 full frames.
  - Required: one frame every 5 cycles, lanes match the stimulus order, frame_count wraps to 4.
- Reset mid-fill: accept 2 words, pulse rst_n low asynchronously between edges.
  - Required: all outputs 0 immediately; the next 4 words form a clean frame with lane_mask=4'b1111.
- Single-word in_last on 16'h7FFF.
  - Required: a=7FFF, b=c=d=PAD; lane_mask=4'b0001.
  - Repeat with PAD=16'h0000 overridden to 16'h5555 and check b=c=d=5555.

Source files
------------

// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//   Input stage of the 4-input descending sorter. It packs a serial word
//   stream into 4-lane frames (word 0 -> a ... word 3 -> d). A fill buffer
//   collects the words. A hold buffer presents the finished frame on stable
//   parallel outputs, so the next frame can load while the current one waits.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_data/in_valid    : incoming word and its valid
//   in_last             : ends a short frame early (sampled only on accept)
//   in_ready            : loader can accept a word (state-decoded only)
//   a, b, c, d          : frame lanes 0..3 from the hold buffer
//   lane_mask           : bit k set = lane k holds real data, clear = PAD
//   frame_valid         : hold buffer holds a complete frame
//   frame_ready         : downstream consumes the frame
//   frame_count         : frames delivered, wraps modulo 256
module sort_frame_loader #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] PAD   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       lane_mask,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [7:0]       frame_count
);

    typedef enum logic {
        S_FILLING = 1'b0,
        S_FULL    = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0][WIDTH-1:0]       fill_q, fill_d;
    logic [3:0]                  fill_mask_q, fill_mask_d;
    logic [3:0][WIDTH-1:0]       hold_q, hold_d;
    logic [3:0]                  hold_mask_q, hold_mask_d;
    logic                        frame_valid_q, frame_valid_d;
    logic [7:0]                  frame_count_q, frame_count_d;

    logic transfer;
    logic consume;

    // A full fill buffer moves into hold whenever hold is empty or is
    // being drained on the same edge.
    assign transfer = (state_q == S_FULL) && (!frame_valid_q || frame_ready);
    assign consume  = frame_valid_q && frame_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fill_d        = fill_q;
        fill_mask_d   = fill_mask_q;
        hold_d        = hold_q;
        hold_mask_d   = hold_mask_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;

        case (state_q)
            S_FILLING: begin
                if (in_valid) begin
                    fill_d[idx_q]      = in_data;
                    fill_mask_d[idx_q] = 1'b1;
                    if (idx_q == 2'd3 || in_last) begin
                        state_d = S_FULL;
                        // Lanes beyond the last written one get PAD.
                        // Their mask bits are already clear.
                        for (int j = 0; j < 4; j++) begin
                            if (j > int'(idx_q)) begin
                                fill_d[j] = PAD;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_FULL: begin
                if (transfer) begin
                    hold_d        = fill_q;
                    hold_mask_d   = fill_mask_q;
                    frame_valid_d = 1'b1;
                    state_d       = S_FILLING;
                    idx_d         = 2'd0;
                    fill_mask_d   = 4'b0000;
                end
            end
            default: state_d = S_FILLING;
        endcase

        if (consume && !transfer) begin
            frame_valid_d = 1'b0;
        end
        if (consume) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILLING;
            idx_q         <= 2'd0;
            fill_mask_q   <= 4'b0000;
            hold_q        <= '0;
            hold_mask_q   <= 4'b0000;
            frame_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fill_mask_q   <= fill_mask_d;
            hold_q        <= hold_d;
            hold_mask_q   <= hold_mask_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    // The fill lanes need no reset. Every lane is either written or set to
    // PAD before a transfer can read it.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    assign in_ready    = (state_q == S_FILLING);
    assign a           = hold_q[0];
    assign b           = hold_q[1];
    assign c           = hold_q[2];
    assign d           = hold_q[3];
    assign lane_mask   = hold_mask_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;

endmodule
